// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// Holds the FSM state encoding, default widths and port identifiers.
package ram_arbiter_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_ADDR_W = DEF_WIDTH / 2;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; the pointer remembers the last granted port
// and moves only when the caller actually issues a grant.
module rr_arb2
  import ram_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       grant,
  output logic       winner,
  output logic       any
);

  logic last_r;

  assign any = |req;

  // Pick the sole requester, or on a tie the port not granted last.
  always_comb begin
    winner = PORT_CPU;
    case (req)
      2'b01:   winner = PORT_CPU;
      2'b10:   winner = PORT_LDR;
      2'b11:   winner = (last_r == PORT_CPU) ? PORT_LDR : PORT_CPU;
      default: winner = PORT_CPU;
    endcase
  end

  // Last-grant pointer; reset value lets the loader win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r <= PORT_CPU;
    end else if (grant && any) begin
      last_r <= winner;
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates a CPU port and a program-loader port onto one single-port RAM.
// Each access walks IDLE -> GRANT -> ACCESS -> DONE using latched request data.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [WIDTH/2-1:0]    cpu_addr,
  input  logic [WIDTH-1:0]      cpu_wdata,
  input  logic                  ldr_req,
  input  logic                  ldr_we,
  input  logic [WIDTH/2-1:0]    ldr_addr,
  input  logic [WIDTH-1:0]      ldr_wdata,
  output logic                  cpu_gnt,
  output logic                  ldr_gnt,
  output logic                  cpu_done,
  output logic                  ldr_done,
  output logic [WIDTH-1:0]      rdata,
  output logic [WIDTH/2-1:0]    ram_addr,
  input  logic [WIDTH-1:0]      ram_rdata,
  output logic                  ram_wr_en,
  output logic                  ram_rd_en,
  output logic [WIDTH-1:0]      bus_out,
  output logic                  bus_oe,
  output logic                  busy
);

  localparam int ADDR_W = WIDTH / 2;

  state_e             state_r, state_next;
  logic               grant_s, winner_s, any_s;
  logic               owner_r, owner_next;
  logic               we_r, we_next;
  logic [ADDR_W-1:0]  addr_r, addr_next;
  logic [WIDTH-1:0]   wdata_r, wdata_next;
  logic               busy_next, wr_next, rd_next;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({ldr_req, cpu_req}),
    .grant  (grant_s),
    .winner (winner_s),
    .any    (any_s)
  );

  // Next-state logic: requests are only looked at in IDLE.
  always_comb begin
    state_next = state_r;
    grant_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (any_s) begin
          state_next = GRANT;
          grant_s    = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      GRANT:   state_next = ACCESS;
      ACCESS:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture the winner's command on the grant; hold it for the whole access.
  always_comb begin
    owner_next = owner_r;
    we_next    = we_r;
    addr_next  = addr_r;
    wdata_next = wdata_r;
    if (grant_s) begin
      owner_next = winner_s;
      if (winner_s == PORT_LDR) begin
        we_next    = ldr_we;
        addr_next  = ldr_addr;
        wdata_next = ldr_wdata;
      end else begin
        we_next    = cpu_we;
        addr_next  = cpu_addr;
        wdata_next = cpu_wdata;
      end
    end else begin
      owner_next = owner_r;
    end
  end

  assign busy_next = (state_next != IDLE);
  assign wr_next   = (state_next == ACCESS) && we_r;
  assign rd_next   = (state_next == ACCESS) && !we_r;
  assign ram_addr  = addr_r;

  // State, command latches and all outputs registered off the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      owner_r   <= PORT_CPU;
      we_r      <= 1'b0;
      addr_r    <= '0;
      wdata_r   <= '0;
      cpu_gnt   <= 1'b0;
      ldr_gnt   <= 1'b0;
      cpu_done  <= 1'b0;
      ldr_done  <= 1'b0;
      ram_wr_en <= 1'b0;
      ram_rd_en <= 1'b0;
      bus_oe    <= 1'b0;
      bus_out   <= '0;
      busy      <= 1'b0;
      rdata     <= '0;
    end else begin
      state_r   <= state_next;
      owner_r   <= owner_next;
      we_r      <= we_next;
      addr_r    <= addr_next;
      wdata_r   <= wdata_next;
      cpu_gnt   <= busy_next && (owner_next == PORT_CPU);
      ldr_gnt   <= busy_next && (owner_next == PORT_LDR);
      cpu_done  <= (state_next == DONE) && (owner_next == PORT_CPU);
      ldr_done  <= (state_next == DONE) && (owner_next == PORT_LDR);
      ram_wr_en <= wr_next;
      ram_rd_en <= rd_next;
      bus_oe    <= wr_next;
      bus_out   <= wr_next ? wdata_r : '0;
      busy      <= busy_next;
      rdata     <= ((state_r == ACCESS) && !we_r) ? ram_rdata : rdata;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed, table-driven bench for ram_arbiter with a behavioural 16x8 RAM.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [3:0] cpu_addr = 4'h0;
  logic [7:0] cpu_wdata = 8'h00;
  logic       ldr_req = 1'b0, ldr_we = 1'b0;
  logic [3:0] ldr_addr = 4'h0;
  logic [7:0] ldr_wdata = 8'h00;
  logic       cpu_gnt, ldr_gnt, cpu_done, ldr_done;
  logic [7:0] rdata, ram_rdata, bus_out;
  logic [3:0] ram_addr;
  logic       ram_wr_en, ram_rd_en, bus_oe, busy;

  ram_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .cpu_gnt(cpu_gnt), .ldr_gnt(ldr_gnt), .cpu_done(cpu_done), .ldr_done(ldr_done),
    .rdata(rdata), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
    .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en), .bus_out(bus_out), .bus_oe(bus_oe),
    .busy(busy)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [16];
  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) if (ram_wr_en) mem[ram_addr] <= bus_out;

  int checks = 0, failures = 0, viol = 0, busy_cnt = 0;

  always @(clk) begin
    if ((ram_wr_en === 1'b1 && ram_rd_en === 1'b1) || (bus_oe === 1'b1 && ram_wr_en !== 1'b1))
      viol++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] obs();
    return {cpu_gnt, ldr_gnt, cpu_done, ldr_done, ram_wr_en, ram_rd_en, bus_oe, busy};
  endfunction

  typedef struct {
    logic       rst;
    logic       creq;
    logic       lreq;
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic       chg;
    logic       exp_ldr;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t tbl [39];

  task automatic do_reset();
    rst_n = 1'b0;
    cpu_req = 1'b0;
    ldr_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One access: drive at a negedge in IDLE, then sample GRANT/ACCESS/DONE/IDLE.
  task automatic run(input vec_t v);
    logic [1:0] g;
    g = v.exp_ldr ? 2'b01 : 2'b10;
    cpu_req = v.creq;  ldr_req = v.lreq;
    cpu_we = v.we;     ldr_we = v.we;
    cpu_addr = v.addr; ldr_addr = v.addr;
    cpu_wdata = v.wdata; ldr_wdata = v.wdata;
    @(posedge clk);
    @(negedge clk);
    check("grant_phase", 32'(obs()), 32'({g, 2'b00, 3'b000, 1'b1}));
    check("addr_grant", 32'(ram_addr), 32'(v.addr));
    busy_cnt += int'(busy);
    cpu_req = 1'b0; ldr_req = 1'b0;
    cpu_we = ~v.we; ldr_we = ~v.we;
    cpu_addr = v.chg ? 4'h9 : ~v.addr;
    ldr_addr = ~v.addr;
    cpu_wdata = ~v.wdata; ldr_wdata = ~v.wdata;
    @(negedge clk);
    check("access_phase", 32'(obs()), 32'({g, 2'b00, v.we, ~v.we, v.we, 1'b1}));
    check("addr_access", 32'(ram_addr), 32'(v.addr));
    if (v.we) check("bus_out", 32'(bus_out), 32'(v.wdata));
    busy_cnt += int'(busy);
    @(negedge clk);
    check("done_phase", 32'(obs()), 32'({g, g, 3'b000, 1'b1}));
    if (!v.we) check("rdata", 32'(rdata), 32'(v.exp_rd));
    busy_cnt += int'(busy);
    @(negedge clk);
    check("idle_phase", 32'(obs()), 32'h0);
    busy_cnt += int'(busy);
  endtask

  initial begin
    vec_t v;
    //          rst   creq  lreq  we    addr  wdata  chg   ldr   rd
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'h3, 8'hA5, 1'b0, 1'b1, 8'h00};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 8'h00, 1'b0, 1'b0, 8'hA5};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'h3, 8'h00, 1'b0, 1'b1, 8'hA5};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h3, 8'h00, 1'b0, 1'b0, 8'hA5};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h3, 8'h00, 1'b0, 1'b1, 8'hA5};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h3, 8'h00, 1'b0, 1'b0, 8'hA5};
    for (int i = 0; i < 16; i++) begin
      tbl[6 + i]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'(i), 8'(i), 1'b0, 1'b1, 8'h00};
      tbl[22 + i] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'(i), 8'h00, 1'b0, 1'b0, 8'(i)};
    end
    tbl[38] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 8'h00, 1'b1, 1'b0, 8'h02};

    @(negedge clk);
    check("rst_ctrl", 32'(obs()), 32'h0);
    check("rst_ram_addr", 32'(ram_addr), 32'h0);
    check("rst_bus_out", 32'(bus_out), 32'h0);
    check("rst_rdata", 32'(rdata), 32'h0);

    for (int i = 0; i < 39; i++) begin
      if (tbl[i].rst) do_reset();
      if (i == 6) busy_cnt = 0;
      run(tbl[i]);
      if (i == 37) check("busy_3_of_4", 32'(busy_cnt), 32'd96);
    end

    // Reset in the middle of a write ACCESS must abort it without a done.
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 4'h5; ldr_wdata = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    ldr_req = 1'b0;
    @(negedge clk);
    check("wr_before_rst", 32'({ram_wr_en, bus_oe}), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", 32'(obs()), 32'h0);
    check("rst_async_bus", 32'(bus_out), 32'h0);
    @(negedge clk);
    check("rst_no_done", 32'(obs()), 32'h0);
    rst_n = 1'b1;
    v = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h5, 8'h00, 1'b0, 1'b1, 8'h05};
    run(v);

    check("strobe_exclusive", 32'(viol), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
